zone_input_conditioner: RTL

ZONE_INPUT_CONDITIONER -- requirements
Module: zone_input_conditioner

---
 rtl/border_pkg.sv | 16 +
 rtl/debounce_channel.sv | 70 +++++++
 rtl/zone_input_conditioner.sv | 104 ++++++++++
 3 files changed

// File: rtl/border_pkg.sv
// Shared constants and helpers for the border intrusion front end and core.
package border_pkg;

    localparam int unsigned NUM_ZONES    = 4;
    localparam int unsigned DBNC_CNT_W   = 8;
    localparam int unsigned WIN_CNT_W    = 16;
    localparam int unsigned GLITCH_CNT_W = 4;

    typedef logic [GLITCH_CNT_W-1:0] glitch_cnt_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic glitch_cnt_t sat_inc(input glitch_cnt_t c);
        return (c == '1) ? c : c + glitch_cnt_t'(1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One conditioned input: 2-flop synchronizer, debounce counter, clean level,
// rise pulse and a glitch strobe for runs that end before the debounce time.
module debounce_channel
    import border_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic clean_o,
    output logic rise_o,
    output logic glitch_o
);

    localparam logic [DBNC_CNT_W-1:0] CntLast = DBNC_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                  meta_q, sync_q;
    logic                  clean_q, clean_d;
    logic                  rise_q, rise_d;
    logic [DBNC_CNT_W-1:0] cnt_q, cnt_d;

    // Two-stage synchronizer; only sync_q is used downstream.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= raw_i;
            sync_q <= meta_q;
        end
    end

    // Count consecutive disagreeing cycles; flip on the last, strobe a glitch on early abort.
    always_comb begin
        cnt_d    = cnt_q;
        clean_d  = clean_q;
        rise_d   = 1'b0;
        glitch_o = 1'b0;
        if (sync_q != clean_q) begin
            if (cnt_q == CntLast) begin
                clean_d = ~clean_q;
                cnt_d   = '0;
                rise_d  = ~clean_q;
            end else begin
                cnt_d = cnt_q + DBNC_CNT_W'(1);
            end
        end else if (cnt_q != '0) begin
            cnt_d    = '0;
            glitch_o = 1'b1;
        end
    end

    // Debounce state and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
        end
    end

    assign clean_o = clean_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/zone_input_conditioner.sv
// Conditions raw zone and arm switches for the intrusion core: debounce,
// rise detection and per-zone chatter flagging over a fixed window.
module zone_input_conditioner
    import border_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CHATTER_WINDOW  = 1024,
    parameter int unsigned CHATTER_LIMIT   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_ZONES-1:0] zone_raw,
    input  logic                 arm_raw,
    input  logic                 chatter_clr,
    output logic [NUM_ZONES-1:0] zone_clean,
    output logic                 arm_clean,
    output logic [NUM_ZONES-1:0] zone_rise,
    output logic                 arm_rise,
    output logic [NUM_ZONES-1:0] chatter
);

    localparam logic [WIN_CNT_W-1:0]    WinLast  = WIN_CNT_W'(CHATTER_WINDOW - 1);
    localparam logic [GLITCH_CNT_W:0]   LimitVal = (GLITCH_CNT_W + 1)'(CHATTER_LIMIT);

    logic [NUM_ZONES-1:0] zone_glitch;
    logic                 arm_glitch_unused;
    logic [WIN_CNT_W-1:0] win_q;
    logic                 win_wrap;
    glitch_cnt_t          gcnt_q [NUM_ZONES];
    glitch_cnt_t          gcnt_d [NUM_ZONES];
    logic [NUM_ZONES-1:0] chatter_q, chatter_d, chatter_set;

    for (genvar i = 0; i < NUM_ZONES; i++) begin : g_zone
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .clk_i   (clk),
            .rst_ni  (rst),
            .raw_i   (zone_raw[i]),
            .clean_o (zone_clean[i]),
            .rise_o  (zone_rise[i]),
            .glitch_o(zone_glitch[i])
        );
    end

    // Arm glitches are not tracked for chatter.
    debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_arm (
        .clk_i   (clk),
        .rst_ni  (rst),
        .raw_i   (arm_raw),
        .clean_o (arm_clean),
        .rise_o  (arm_rise),
        .glitch_o(arm_glitch_unused)
    );

    assign win_wrap = (win_q == WinLast);

    // Free-running window counter shared by all zones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_q <= '0;
        end else if (win_wrap) begin
            win_q <= '0;
        end else begin
            win_q <= win_q + WIN_CNT_W'(1);
        end
    end

    // Glitch counting per window; a glitch landing on the wrap cycle is dropped.
    always_comb begin
        for (int i = 0; i < NUM_ZONES; i++) begin
            gcnt_d[i]      = gcnt_q[i];
            chatter_set[i] = 1'b0;
            if (win_wrap) begin
                gcnt_d[i] = '0;
            end else if (zone_glitch[i]) begin
                gcnt_d[i]      = sat_inc(gcnt_q[i]);
                chatter_set[i] = (({1'b0, gcnt_q[i]} + (GLITCH_CNT_W + 1)'(1)) == LimitVal);
            end
        end
        // Set wins over a simultaneous clear.
        chatter_d = (chatter_q & ~{NUM_ZONES{chatter_clr}}) | chatter_set;
    end

    // Glitch counters and sticky chatter flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_ZONES; i++) begin
                gcnt_q[i] <= '0;
            end
            chatter_q <= '0;
        end else begin
            for (int i = 0; i < NUM_ZONES; i++) begin
                gcnt_q[i] <= gcnt_d[i];
            end
            chatter_q <= chatter_d;
        end
    end

    assign chatter = chatter_q;

endmodule
